// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state type, fixed latency and operand-signedness helpers.
package rv32m_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Cycles from the accepting edge's cycle (cycle 0) to the done cycle.
  localparam int MD_LATENCY = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// FIX-stage result formation: sign correction of the unsigned magnitude
// result, result selection by funct3 and the divide special-case overrides.
module muldiv_sign_fix
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] hi_i,        // product high half / remainder
  input  logic [XLEN-1:0] lo_i,        // product low half / quotient
  input  logic            neg_a_i,
  input  logic            neg_b_i,
  input  logic            div_zero_i,
  input  logic            ovf_i,
  output logic [XLEN-1:0] result_o
);

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  // Negate magnitudes where needed, then pick the field funct3 asks for.
  // A zero divisor leaves the remainder equal to |A| with A's sign, which is
  // A itself, so only the quotient needs an explicit override.
  always_comb begin
    prod     = {hi_i, lo_i};
    prod_s   = (neg_a_i ^ neg_b_i) ? -prod : prod;
    quo_s    = (neg_a_i ^ neg_b_i) ? -lo_i : lo_i;
    rem_s    = neg_a_i ? -hi_i : hi_i;
    result_o = '0;
    case (op_i)
      OP_MUL:                       result_o = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result_o = quo_s;
      OP_REM, OP_REMU:              result_o = rem_s;
      default:                      result_o = '0;
    endcase
    if (op_i[2] && !op_i[1] && div_zero_i) begin
      result_o = '1;
    end else if (ovf_i) begin
      result_o = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One radix-2 step per cycle through a
// shared 33-bit adder/subtractor and a 64-bit {hi, lo} shift register.
//
// Handshake: start is held high by the core while the M instruction sits in
// execute; it is sampled only in IDLE. stall stays high until the DONE cycle,
// where done pulses for one cycle with result valid; result then holds until
// the next operation finishes.
module muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

  md_state_e       state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic            div_zero_q, div_zero_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic            in_neg_a, in_neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   add_a, add_b;
  logic            add_cin;
  logic [XLEN+1:0] add_sum;
  logic [XLEN-1:0] fix_result;

  assign stall     = (state_q == IDLE) ? start : (state_q != DONE);
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

  // Next-state logic of the control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes at acceptance, taken only for signed operand slots.
  always_comb begin
    in_neg_a = A[XLEN-1] & a_is_signed(op);
    in_neg_b = B[XLEN-1] & b_is_signed(op);
    mag_a    = in_neg_a ? -A : A;
    mag_b    = in_neg_b ? -B : B;
  end

  // Shared adder: add the multiplicand when the multiplier LSB is set, or
  // subtract the divisor from the left-shifted partial remainder. Bit XLEN+1
  // of the sum is the no-borrow flag in divide mode.
  always_comb begin
    if (op_q[2]) begin
      add_a   = {hi_q, lo_q[XLEN-1]};
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, opnd_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_cin};
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_i       (op_q),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .neg_a_i    (neg_a_q),
    .neg_b_i    (neg_b_q),
    .div_zero_i (div_zero_q),
    .ovf_i      (ovf_q),
    .result_o   (fix_result)
  );

  // Datapath next-state: latch on accept, iterate in CALC, register in FIX.
  always_comb begin
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d      = '0;
          op_d       = op;
          neg_a_d    = in_neg_a;
          neg_b_d    = in_neg_b;
          div_zero_d = op[2] && (B == '0);
          ovf_d      = ((op == OP_DIV) || (op == OP_REM)) &&
                       (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
          hi_d       = '0;
          lo_d       = op[2] ? mag_a : mag_b;
          opnd_d     = op[2] ? mag_b : mag_a;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[2]) begin
          if (add_sum[XLEN+1]) begin
            hi_d = add_sum[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = add_a[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          {hi_d, lo_d} = {add_sum[XLEN:0], lo_q[XLEN-1:1]};
        end
      end
      FIX: begin
        result_d = fix_result;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, robustness
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        stall, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p, q;
    logic [63:0] up, ua64, ub64;
    logic [31:0] r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'd0, b});
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    r = '0;
    case (f)
      OP_MUL:    begin p = sa * sb; r = p[31:0]; end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
      OP_MULHU:  begin up = ua64 * ub64; r = up[63:32]; end
      OP_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin q = sa / sb; r = q[31:0]; end
      end
      OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin q = sa % sb; r = q[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge: present an instruction and hold start high.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    op    = f;
    A     = a;
    B     = b;
    start = 1'b1;
    exp_q.push_back(ref_md(f, a, b));
  endtask

  // Current falling edge is cycle 0 of the instruction. Tracks stall every
  // cycle, the done cycle and the result; optionally scrambles the inputs
  // mid-calculation and releases start after done.
  task automatic wait_done(input bit mutate, input bit drop_start);
    int stall_bad = 0;
    int done_cyc  = -1;
    logic [31:0] exp;
    #1;
    if (stall !== 1'b1) stall_bad++;
    for (int k = 1; k <= 100 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (mutate && k == 5) begin
        op = 3'($urandom_range(0, 7));
        A  = $urandom;
        B  = $urandom;
      end
      if (done === 1'b1) begin
        done_cyc = k;
        if (stall !== 1'b0) stall_bad++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        last_exp = exp;
        check_eq("result", result, exp);
      end else if (stall !== 1'b1) begin
        stall_bad++;
      end
    end
    check_eq("done_cycle", done_cyc, MD_LATENCY);
    check_eq("stall_shape", stall_bad, 0);
    if (drop_start) begin
      start = 1'b0;
      @(negedge clk);
      check_eq("done_pulse", {31'd0, done}, 32'd0);
      check_eq("result_hold", result, last_exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b);
    wait_done(1'b0, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int sel;

    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD);
    run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000);
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2);
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2);
    run_op(OP_DIVU,   32'h1234_5678,  32'd0);
    run_op(OP_REMU,   32'h1234_5678,  32'd0);
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF);
    run_op(OP_DIV,    32'hFFFF_FFFB,  32'd0);
    run_op(OP_REM,    32'hFFFF_FFFB,  32'd0);

    // Inputs scrambled during CALC must not affect the result.
    issue(OP_MULH, 32'h1357_9BDF, 32'hF00D_CAFE);
    wait_done(1'b1, 1'b1);
    issue(OP_REM, 32'h8765_4321, 32'h0000_1234);
    wait_done(1'b1, 1'b1);

    // Reset in the middle of an operation aborts it without a done pulse.
    issue(OP_MULHU, 32'hABCD_EF01, 32'h2345_6789);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_eq("abort_result", result, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_stall", {31'd0, stall}, 32'd0);
    check_eq("abort_state", {30'd0, dbg_state}, 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check_eq("abort_no_done", done_seen, 0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd3);

    // Back-to-back: second start accepted at cycle 35, done at cycle 69.
    issue(OP_MUL, 32'h0001_0003, 32'h0002_0005);
    wait_done(1'b0, 1'b0);
    issue(OP_MUL, 32'hDEAD_BEEF, 32'h0000_0011);
    @(negedge clk);
    wait_done(1'b0, 1'b1);

    // Randomized operations with biased special operands.
    for (int i = 0; i < 40; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) ra = 32'($urandom_range(0, 15));
      run_op(rf, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same two register operands the ALU receives and produces a 32-bit result for the write-back mux. It holds the processor through a `stall` output while it computes, so the single-cycle core supports M-extension instructions without a wide combinational multiplier or divider. Latency is fixed for every operation.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  high while an M-type instruction is in execute. Held until `done`.
- `op`  in  3  instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A`  in  32  rs1 operand (multiplicand or dividend).
- `B`  in  32  rs2 operand (multiplier or divisor).
- `stall`  out  1  freezes PC and register-file write while high.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32  final value. Held until the next accepted `start`.

## Operation
- FSM states:
  - IDLE: `start` = 1 → CALC. Latch `op`, magnitudes |A| and |B| (signed ops only), result sign, and special-case flags. Clear the 6-bit counter.
  - CALC: one radix-2 step per cycle. Multiply is shift-add into a 64-bit product. Divide is restoring shift-subtract, producing a 32-bit quotient and remainder. After 32 steps (counter 31) → FIX.
  - FIX: apply the special-case override or the sign correction, then register `result`. → DONE.
  - DONE: `done` = 1. Always → IDLE.
- `start` is sampled only in IDLE. `start` in CALC, FIX or DONE is ignored. Operand or `op` changes after acceptance are ignored.
- Sign rules:
  - MULH treats both operands as signed.
  - MULHSU treats A as signed and B as unsigned.
  - DIV and REM are signed.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Result selection:
  - MUL returns the low 32 bits of the product.
  - MULH, MULHSU and MULHU return the high 32 bits.
  - DIV and DIVU return the quotient.
  - REM and REMU return the remainder.
- Special cases are resolved in FIX and keep the normal latency:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → A.
  - Signed overflow, A = 0x80000000 with B = 0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- `stall` = (`start` AND state == IDLE) OR state ∈ {CALC, FIX}. It is low in DONE, so the core retires the instruction in that cycle.
- `op` and `start` are decoded outside this block.

## Timing
- Edge 0: `start` sampled in IDLE.
- CALC occupies cycles 1–32. FIX is cycle 33. DONE is cycle 34: `done` = 1 and `result` valid.
- The instruction therefore retires 35 cycles after it enters execute, including cycle 0.
- IDLE is re-entered at cycle 35. A back-to-back M instruction is accepted on that edge.
- Reset values: state IDLE, `done` 0, `stall` 0, `result` 0x00000000, counter 0, all datapath registers 0.
- `rst_n` low mid-operation immediately aborts: return to IDLE with all reset values and no `done` pulse.
- `stall` is combinational from `start` only in IDLE. All other outputs are registered.
- Counter width is 6 bits. It never wraps, because it is cleared on every accept.

## Structure
- The shared package `rv32m_pkg` holds:
  - the funct3 localparams `OP_MUL`…`OP_REMU`;
  - the FSM state enum `{IDLE, CALC, FIX, DONE}`;
  - `MD_LATENCY` = 34.
- One module holds the FSM, the counter and the shared 64-bit shift register.
- Multiply and divide reuse one 33-bit adder/subtractor.
- No sub-module is required. An optional `muldiv_sign_fix` may hold the FIX-stage negation and override logic.

## Test plan
- MUL, A = 7, B = 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB. `done` exactly at cycle 34. `stall` high cycles 0–33, low at 34.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU A = 0xFFFFFFFF, B = 0xFFFFFFFF → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide, A = 0xFFFFFFF9 (−7), B = 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
- Special cases:
  - DIVU A = 0x12345678, B = 0 → 0xFFFFFFFF.
  - REMU with the same operands → 0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
  - All four complete in 34 cycles.
- Robustness:
  - Change A, B and `op` during CALC → `result` unchanged.
  - Pulse `rst_n` low at cycle 15 → outputs at reset values, no `done`. A new `start` then completes normally.
  - Two back-to-back MUL instructions → the second is accepted at cycle 35 and its `done` arrives at cycle 69.
